// File: rtl/proc_defs.sv
// Shared processor definitions: PC selector encodings and fetch FSM states.
package proc_defs;

    localparam int SEL_W = 2;

    typedef enum logic [SEL_W-1:0] {
        PC_NEXT = 2'd0,
        PC_KEEP = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: steers the PC, issues req/ack memory reads and
// hands fetched words to decode over valid/ready, squashing wrong-path words.
module instr_fetch
    import proc_defs::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WORD_SIZE-1:0] pc_addr,
    output logic [SEL_W-1:0]     pc_sel,
    output logic [WORD_SIZE-1:0] pc_target,
    output logic                 mem_req,
    output logic [ADDR_SIZE-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 jmp_valid,
    input  logic [WORD_SIZE-1:0] jmp_target,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] instr_data,
    output logic [WORD_SIZE-1:0] instr_pc,
    input  logic                 instr_ready
);

    fetch_state_e         state_r, state_nxt_s;
    logic                 jmp_pend_r, jmp_pend_nxt_s;
    logic [WORD_SIZE-1:0] tgt_q_r, tgt_q_nxt_s;
    logic [WORD_SIZE-1:0] instr_data_r, instr_pc_r;
    logic                 capture_s;
    pc_sel_e              pc_sel_s;
    logic [WORD_SIZE-1:0] pc_target_s;

    // Next-state, PC steering and capture decisions
    always_comb begin
        state_nxt_s    = state_r;
        jmp_pend_nxt_s = jmp_pend_r;
        tgt_q_nxt_s    = tgt_q_r;
        capture_s      = 1'b0;
        pc_sel_s       = PC_KEEP;
        pc_target_s    = {WORD_SIZE{1'b0}};
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_FETCH;
                if (jmp_valid) begin
                    pc_sel_s    = PC_LOAD;
                    pc_target_s = jmp_target;
                end else begin
                    pc_sel_s = PC_KEEP;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    if (jmp_valid || jmp_pend_r) begin
                        // Returned word is wrong-path; redirect and refetch
                        pc_sel_s       = PC_LOAD;
                        pc_target_s    = jmp_valid ? jmp_target : tgt_q_r;
                        jmp_pend_nxt_s = 1'b0;
                    end else begin
                        pc_sel_s    = PC_NEXT;
                        capture_s   = 1'b1;
                        state_nxt_s = ST_VALID;
                    end
                end else if (jmp_valid) begin
                    // Address must stay put until ack, so remember the target
                    jmp_pend_nxt_s = 1'b1;
                    tgt_q_nxt_s    = jmp_target;
                end else begin
                    pc_sel_s = PC_KEEP;
                end
            end
            ST_VALID: begin
                if (jmp_valid) begin
                    pc_sel_s    = PC_LOAD;
                    pc_target_s = jmp_target;
                    state_nxt_s = ST_FETCH;
                end else if (instr_ready) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_VALID;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, pending-jump and fetched-word registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            jmp_pend_r   <= 1'b0;
            tgt_q_r      <= {WORD_SIZE{1'b0}};
            instr_data_r <= {WORD_SIZE{1'b0}};
            instr_pc_r   <= {WORD_SIZE{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            jmp_pend_r <= jmp_pend_nxt_s;
            tgt_q_r    <= tgt_q_nxt_s;
            if (capture_s) begin
                instr_data_r <= mem_rdata;
                instr_pc_r   <= pc_addr;
            end else begin
                instr_data_r <= instr_data_r;
                instr_pc_r   <= instr_pc_r;
            end
        end
    end

    assign mem_req     = (state_r == ST_FETCH);
    assign mem_addr    = pc_addr[ADDR_SIZE-1:0];
    assign instr_valid = (state_r == ST_VALID);
    assign instr_data  = instr_data_r;
    assign instr_pc    = instr_pc_r;
    assign pc_sel      = pc_sel_s;
    assign pc_target   = pc_target_s;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC and memory environment, directed scenarios plus
// randomized traffic checked by a scoreboard of the expected instruction stream.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic [1:0]  pc_sel;
    logic [31:0] pc_target;
    logic        mem_req;
    logic [13:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int lat;
    bit ack_force;
    int wcnt;
    int n_checks = 0;
    int n_errors = 0;
    int n_xfer = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] next_pc;

    always #5 clk = ~clk;

    instr_fetch #(.WORD_SIZE(32), .ADDR_SIZE(14)) dut (
        .clk(clk), .rst_n(rst_n), .pc_addr(pc), .pc_sel(pc_sel),
        .pc_target(pc_target), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .jmp_valid(jmp_valid),
        .jmp_target(jmp_target), .instr_valid(instr_valid),
        .instr_data(instr_data), .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 + {18'd0, a[13:0]};
    endfunction

    // Program counter of the surrounding core
    always @(posedge clk) begin
        if (!rst_n) pc <= 32'd0;
        else if (pc_sel == 2'd0) pc <= pc + 32'd1;
        else if (pc_sel == 2'd2) pc <= pc_target;
        else pc <= pc;
    end

    // Instruction memory with configurable wait states
    always @(posedge clk) begin
        if (!rst_n || !mem_req || mem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end
    assign mem_ack   = ack_force || (mem_req && (wcnt >= lat));
    assign mem_rdata = mem_ack ? mem_word({18'd0, mem_addr}) : 32'hDEAD_BEEF;

    // Expected stream: architectural fetch order, restarted at every jump
    function automatic void sb_refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back('{next_pc, mem_word(next_pc)});
            next_pc = next_pc + 32'd1;
        end
    endfunction

    function automatic void sb_restart(input logic [31:0] start);
        exp_q.delete();
        next_pc = start;
        sb_refill();
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted, non-squashed transfer must match the stream head
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && instr_valid && instr_ready && !jmp_valid) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    check("xfer_unexpected", instr_pc, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("xfer_pc", instr_pc, mon_e.pc);
                    check("xfer_data", instr_data, mon_e.data);
                    sb_refill();
                end
            end
        end
    end

    task automatic do_reset(input bit jmp_idle, input logic [31:0] tgt);
        @(negedge clk);
        rst_n = 1'b0;
        jmp_valid = 1'b0;
        ack_force = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 32'd0);
        check("rst_instr_valid", instr_valid, 32'd0);
        check("rst_pc_sel", pc_sel, 32'd1);
        check("rst_pc_target", pc_target, 32'd0);
        check("rst_instr_data", instr_data, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        ack_force = 1'b0;
        rst_n = 1'b1;
        sb_restart(jmp_idle ? tgt : 32'd0);
        if (jmp_idle) begin
            jmp_valid = 1'b1;
            jmp_target = tgt;
            #1;
            check("idle_pc_sel", pc_sel, 32'd2);
            check("idle_pc_target", pc_target, tgt);
        end
        @(negedge clk);
        jmp_valid = 1'b0;
        check("first_req", mem_req, 32'd1);
        check("first_addr", {18'd0, mem_addr}, jmp_idle ? {18'd0, tgt[13:0]} : 32'd0);
    endtask

    logic [13:0] a;
    logic [31:0] d, p, t;
    int n0;

    initial begin
        rst_n = 1'b0;
        jmp_valid = 1'b0;
        jmp_target = 32'd0;
        instr_ready = 1'b1;
        lat = 0;
        ack_force = 1'b0;
        sb_restart(32'd0);

        // Reset, then zero-wait sequential fetch: one word every two cycles
        do_reset(1'b0, 32'd0);
        n0 = n_xfer;
        repeat (8) @(negedge clk);
        check("zero_wait_rate", n_xfer - n0, 32'd4);

        // Three wait states: address and KEEP stable, valid four cycles on
        lat = 3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_valid) break;
        end
        check("ws_sync", instr_valid, 32'd1);
        @(negedge clk);
        check("ws_req", mem_req, 32'd1);
        a = mem_addr;
        for (int k = 0; k < 3; k++) begin
            check("ws_addr", {18'd0, mem_addr}, {18'd0, a});
            check("ws_keep", pc_sel, 32'd1);
            @(negedge clk);
        end
        check("ws_ack_addr", {18'd0, mem_addr}, {18'd0, a});
        check("ws_next", pc_sel, 32'd0);
        @(negedge clk);
        check("ws_valid", instr_valid, 32'd1);
        check("ws_instr_pc", instr_pc, {18'd0, a});

        // Backpressure: decode stalls, output and PC hold
        instr_ready = 1'b0;
        lat = 0;
        do_reset(1'b0, 32'd0);
        for (int i = 0; i < 20; i++) begin
            if (instr_valid) break;
            @(negedge clk);
        end
        d = instr_data;
        p = instr_pc;
        check("bp_pc0", p, 32'd0);
        check("bp_data0", d, mem_word(32'd0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", instr_valid, 32'd1);
            check("bp_data", instr_data, d);
            check("bp_instr_pc", instr_pc, p);
            check("bp_no_req", mem_req, 32'd0);
            check("bp_pc_hold", pc, 32'd1);
        end

        // Jump while a stalled word is presented
        jmp_valid = 1'b1;
        jmp_target = 32'h10;
        sb_restart(32'h10);
        #1;
        check("jv_sel", pc_sel, 32'd2);
        check("jv_target", pc_target, 32'h10);
        @(negedge clk);
        jmp_valid = 1'b0;
        check("jv_valid_drop", instr_valid, 32'd0);
        check("jv_pc", pc, 32'h10);
        check("jv_req_addr", {18'd0, mem_addr}, 32'h10);
        instr_ready = 1'b1;

        // Jump during an outstanding read of PC 5
        do_reset(1'b0, 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 14'd5) break;
        end
        check("jw_found", {18'd0, mem_addr}, 32'd5);
        lat = 10;
        #1;
        check("jw_wait_keep", pc_sel, 32'd1);
        @(negedge clk);
        jmp_valid = 1'b1;
        jmp_target = 32'h40;
        sb_restart(32'h40);
        #1;
        check("jw_jmp_keep", pc_sel, 32'd1);
        @(negedge clk);
        jmp_valid = 1'b0;
        lat = 0;
        #1;
        check("jw_ack_sel", pc_sel, 32'd2);
        check("jw_ack_target", pc_target, 32'h40);
        check("jw_ack_addr", {18'd0, mem_addr}, 32'd5);
        @(negedge clk);
        check("jw_new_req", mem_req, 32'd1);
        check("jw_new_addr", {18'd0, mem_addr}, 32'h40);

        // Jump coincident with ack overrides an older pending target
        lat = 5;
        jmp_valid = 1'b1;
        jmp_target = 32'h300;
        #1;
        check("jc_pend_keep", pc_sel, 32'd1);
        @(negedge clk);
        jmp_target = 32'h200;
        lat = 0;
        sb_restart(32'h200);
        #1;
        check("jc_sel", pc_sel, 32'd2);
        check("jc_target", pc_target, 32'h200);
        @(negedge clk);
        jmp_valid = 1'b0;
        check("jc_new_addr", {18'd0, mem_addr}, 32'h200);

        // Jump in IDLE to an address wider than the memory port
        do_reset(1'b1, 32'h0001_4005);
        repeat (6) @(negedge clk);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            check("rnd_mem_addr", {18'd0, mem_addr}, {18'd0, pc[13:0]});
            if (pc_sel != 2'd2) check("rnd_target_zero", pc_target, 32'd0);
            lat = $urandom_range(0, 3);
            instr_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0: t = 32'hFFFF_FFFE;
                    1: t = $urandom;
                    2: t = $urandom_range(0, 255);
                    default: t = 32'h0000_3FFE;
                endcase
                jmp_valid = 1'b1;
                jmp_target = t;
                sb_restart(t);
            end else begin
                jmp_valid = 1'b0;
            end
        end
        @(negedge clk);
        jmp_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("xfer_seen", (n_xfer > 200) ? 32'd1 : 32'd0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
